edge_detector: RTL and testbench
================================

EDGE_DETECTOR -- requirements
Module: edge_detector

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of input synchronizer flops; legal range is 2 to 4.
REQ-002 Parameter EDGE_MODE, default 0, selects the edge that drives q: 0 = rising, 1 = falling, 2 = both.
REQ-003 Parameter CNT_W, default 8, width of edge_cnt; legal range is 1 to 32.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 d  input  1  asynchronous level input to monitor.
REQ-007 q  output  1  registered one-clock pulse on the edge selected by EDGE_MODE.
REQ-008 rise  output  1  registered one-clock pulse on each rising edge of d.
REQ-009 fall  output  1  registered one-clock pulse on each falling edge of d.
REQ-010 edge_cnt  output  CNT_W  count of q pulses; present only when the counter macro is defined.

Function
REQ-011 d SHALL pass through a chain of SYNC_STAGES flops (s[0] <= d, s[i] <= s[i-1]); only the last stage s_out feeds the detection logic.
REQ-012 A history flop SHALL store the previous s_out (prev <= s_out) every clock.
REQ-013 rise SHALL be registered as s_out & ~prev; fall SHALL be registered as ~s_out & prev.
REQ-014 q SHALL be registered as rise-term, fall-term or their OR, per EDGE_MODE.
REQ-015 Latency: if posedge N is the first edge that samples a new d level, the pulse SHALL be high from posedge N+SYNC_STAGES to posedge N+SYNC_STAGES+1 (default: N+2 to N+3).
REQ-016 Each pulse SHALL last exactly one clock; a d level held for any length SHALL yield exactly one pulse per transition.
REQ-017 rise and fall SHALL never be high in the same cycle.
REQ-018 A d pulse shorter than one clock period MAY be missed; no pulse SHALL be emitted for a transition that is not sampled.
REQ-019 Back-to-back transitions one clock apart in s_out SHALL produce pulses in consecutive cycles (rise then fall).
REQ-020 An EDGE_MODE value outside 0 to 2 SHALL behave as 0.

Reset
REQ-021 While rst is 0, all synchronizer flops, prev, q, rise, fall and edge_cnt SHALL be 0, asynchronously and with no clock required.
REQ-022 After rst is released, a d held high through the release SHALL produce one rise pulse, because the history resets to 0.
REQ-023 Asserting rst during a pulse SHALL clear it immediately; no pulse SHALL be emitted for the interrupted event after release unless REQ-022 applies.

Configuration
REQ-024 Macro EDGE_DETECTOR_COUNTER_EN: when defined, edge_cnt SHALL exist and increment by 1 on every cycle in which q is registered high.
REQ-025 edge_cnt SHALL wrap from 2^CNT_W-1 to 0, and SHALL be reset to 0 by rst.
REQ-026 When the macro is undefined, the edge_cnt port and its counter logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Scenario 1: rst=0 with d toggling -> q, rise, fall and edge_cnt all stay 0.
REQ-028 Scenario 2: defaults; rst released with d=0; d=1 after 4 clocks, d=0 after 4 more clocks, repeated twice -> exactly 2 q pulses, each 1 clock wide, 2 clocks after the sampling edge; edge_cnt=2.
REQ-029 Scenario 3: EDGE_MODE=2 with the same stimulus -> 4 q pulses; rise and fall alternate; edge_cnt=4.
REQ-030 Scenario 4: d held at 1 across reset release -> one rise pulse at posedge 3 after release; no further pulses.
REQ-031 Scenario 5: CNT_W=2, 5 rising edges -> edge_cnt sequence 1, 2, 3, 0, 1.
REQ-032 Scenario 6: rst asserted in the cycle a pulse is high -> q drops without waiting for a clock; output is clean after release.

Source files
------------

// File: rtl/edge_detector.sv
// Synchronised edge detector with registered rise/fall/selected-edge pulses.
// Optional pulse counter on edge_cnt enabled by defining EDGE_DETECTOR_COUNTER_EN.
module edge_detector #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int          EDGE_MODE   = 0,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic             q,
    output logic             rise,
`ifdef EDGE_DETECTOR_COUNTER_EN
    output logic             fall,
    output logic [CNT_W-1:0] edge_cnt
`else
    output logic             fall
`endif
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   q_q, q_d;
    logic                   s_out;

    assign s_out = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
        prev_d = s_out;
        rise_d = s_out & ~prev_q;
        fall_d = ~s_out & prev_q;
        // Out-of-range modes fall back to rising-edge detection.
        case (EDGE_MODE)
            1:       q_d = fall_d;
            2:       q_d = rise_d | fall_d;
            default: q_d = rise_d;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            q_q    <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            q_q    <= q_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;

`ifdef EDGE_DETECTOR_COUNTER_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counts on the same edge that registers q, so edge_cnt includes the visible pulse.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(q_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign edge_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_edge_detector.sv
// Directed bench for edge_detector: several parameterisations share one d/rst stream.
// Counter checks are compiled in only when EDGE_DETECTOR_COUNTER_EN is defined.
module tb_edge_detector;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic d   = 1'b0;

    logic q0, r0, f0;
    logic q2, r2, f2;
    logic q1, r1, f1;
    logic q3, r3, f3;
    logic qs, rs, fs;
`ifdef EDGE_DETECTOR_COUNTER_EN
    logic [7:0] cnt0, cnt2, cnt1, cnt3;
    logic [1:0] cnts;
`endif

    always #5 clk = ~clk;

    edge_detector u0 (
        .clk(clk), .rst(rst), .d(d), .q(q0), .rise(r0),
`ifdef EDGE_DETECTOR_COUNTER_EN
        .fall(f0), .edge_cnt(cnt0)
`else
        .fall(f0)
`endif
    );

    edge_detector #(.EDGE_MODE(2)) u2 (
        .clk(clk), .rst(rst), .d(d), .q(q2), .rise(r2),
`ifdef EDGE_DETECTOR_COUNTER_EN
        .fall(f2), .edge_cnt(cnt2)
`else
        .fall(f2)
`endif
    );

    edge_detector #(.EDGE_MODE(1)) u1 (
        .clk(clk), .rst(rst), .d(d), .q(q1), .rise(r1),
`ifdef EDGE_DETECTOR_COUNTER_EN
        .fall(f1), .edge_cnt(cnt1)
`else
        .fall(f1)
`endif
    );

    edge_detector #(.EDGE_MODE(5)) u3 (
        .clk(clk), .rst(rst), .d(d), .q(q3), .rise(r3),
`ifdef EDGE_DETECTOR_COUNTER_EN
        .fall(f3), .edge_cnt(cnt3)
`else
        .fall(f3)
`endif
    );

    edge_detector #(.SYNC_STAGES(3), .CNT_W(2)) us (
        .clk(clk), .rst(rst), .d(d), .q(qs), .rise(rs),
`ifdef EDGE_DETECTOR_COUNTER_EN
        .fall(fs), .edge_cnt(cnts)
`else
        .fall(fs)
`endif
    );

    int total = 0;
    int bad   = 0;

    bit hist [0:127];
    int nq0, nq2, nq1, nq3, nqs, first_q0;
    int mc0, mc2, mc1, mc3, mcs;
    logic [1:0] cnts_log [0:63];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit h(input int k);
        return (k < 1) ? 1'b0 : hist[k];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 128; i++) hist[i] = 1'b0;
        for (int i = 0; i < 64; i++) cnts_log[i] = 2'd0;
        nq0 = 0; nq2 = 0; nq1 = 0; nq3 = 0; nqs = 0; first_q0 = 0;
        mc0 = 0; mc2 = 0; mc1 = 0; mc3 = 0; mcs = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_q0"}, {29'd0, q0, r0, f0}, 32'd0);
        check({tag, "_q2"}, {29'd0, q2, r2, f2}, 32'd0);
        check({tag, "_q1"}, {29'd0, q1, r1, f1}, 32'd0);
        check({tag, "_q3"}, {29'd0, q3, r3, f3}, 32'd0);
        check({tag, "_qs"}, {29'd0, qs, rs, fs}, 32'd0);
`ifdef EDGE_DETECTOR_COUNTER_EN
        check({tag, "_cnt"}, {cnt0, cnt2, cnt1, cnt3}, 32'd0);
        check({tag, "_cnts"}, {30'd0, cnts}, 32'd0);
`endif
    endtask

    // Hold reset for two clocks with d at lvl, check async clear, release just after a posedge.
    task automatic apply_reset(input logic lvl);
        rst = 1'b0;
        d   = lvl;
        #1;
        check_all_zero("rst_async");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
    endtask

    // pat[p] is the d level sampled by posedge p after reset release.
    task automatic run_seq(input logic [63:0] pat, input int n);
        bit er2, ef2, er3, ef3;
        for (int p = 1; p <= n; p++) begin
            d       = pat[p];
            hist[p] = pat[p];
            @(posedge clk);
            #1;
            er2 = h(p - 2) & ~h(p - 3);
            ef2 = ~h(p - 2) & h(p - 3);
            er3 = h(p - 3) & ~h(p - 4);
            ef3 = ~h(p - 3) & h(p - 4);
            check("u0", {29'd0, q0, r0, f0}, {29'd0, er2, er2, ef2});
            check("u2", {29'd0, q2, r2, f2}, {29'd0, er2 | ef2, er2, ef2});
            check("u1", {29'd0, q1, r1, f1}, {29'd0, ef2, er2, ef2});
            check("u3", {29'd0, q3, r3, f3}, {29'd0, er2, er2, ef2});
            check("us", {29'd0, qs, rs, fs}, {29'd0, er3, er3, ef3});
            if (q0 && first_q0 == 0) first_q0 = p;
            nq0 += int'(q0); nq2 += int'(q2); nq1 += int'(q1);
            nq3 += int'(q3); nqs += int'(qs);
            mc0 += int'(er2); mc2 += int'(er2 | ef2); mc1 += int'(ef2);
            mc3 += int'(er2); mcs += int'(er3);
`ifdef EDGE_DETECTOR_COUNTER_EN
            cnts_log[p] = cnts;
            check("cnt0", {24'd0, cnt0}, mc0 & 32'hff);
            check("cnt2", {24'd0, cnt2}, mc2 & 32'hff);
            check("cnt1", {24'd0, cnt1}, mc1 & 32'hff);
            check("cnt3", {24'd0, cnt3}, mc3 & 32'hff);
            check("cnts", {30'd0, cnts}, mcs & 32'h3);
`endif
        end
    endtask

    initial begin
        clear_model();

        // Reset held while d toggles: every output stays low.
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = i[0];
            @(posedge clk);
            #1;
            check_all_zero("s1");
        end

        // d low 4, high 4, low 4, high 4, then low.
        apply_reset(1'b0);
        run_seq(64'h0000_0000_0001_E1E0, 24);
        check("s2_nq0", nq0, 2);
        check("s2_first", first_q0, 7);
        check("s2_nq2", nq2, 4);
        check("s2_nq1", nq1, 2);
        check("s2_nq3", nq3, 2);
        check("s2_nqs", nqs, 2);
`ifdef EDGE_DETECTOR_COUNTER_EN
        check("s2_cnt0", {24'd0, cnt0}, 2);
        check("s2_cnt2", {24'd0, cnt2}, 4);
`endif

        // d held high across release: single rise at posedge 3.
        apply_reset(1'b1);
        run_seq(64'h0000_0000_0000_07FE, 10);
        check("s4_nq0", nq0, 1);
        check("s4_first", first_q0, 3);
        check("s4_nq2", nq2, 1);
        check("s4_nq1", nq1, 0);

        // Five rising edges into the 2-bit counter, 3-stage synchroniser.
        apply_reset(1'b0);
        run_seq(64'h0000_0000_000C_CCCC, 26);
        check("s5_nqs", nqs, 5);
`ifdef EDGE_DETECTOR_COUNTER_EN
        check("s5_c1", {30'd0, cnts_log[5]}, 1);
        check("s5_c2", {30'd0, cnts_log[9]}, 2);
        check("s5_c3", {30'd0, cnts_log[13]}, 3);
        check("s5_c4", {30'd0, cnts_log[17]}, 0);
        check("s5_c5", {30'd0, cnts_log[21]}, 1);
`endif

        // Reset asserted while a fall pulse is high clears it without a clock.
        apply_reset(1'b0);
        run_seq(64'h0000_0000_0000_001E, 7);
        check("s6_pre", {29'd0, f0, q1, q2}, 32'd7);
        rst = 1'b0;
        #1;
        check("s6_async", {29'd0, f0, q1, q2}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        clear_model();
        run_seq(64'h0, 8);
        check("s6_after", nq0 + nq1 + nq2 + nq3 + nqs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
